multicycle_control_unit: RTL and testbench

Registered, multi-cycle successor to the single-cycle combinational decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ready/request handshakes to instruction and data memory. It holds the decoded datapath selects stable for the whole instruction and issues single-cycle write strobes. It sits between the PC/IR registers and the datapath (register bank, ALU, flags, data memory, branch comparator). Instruction width, ALU opcode width and the memory-wait timeout are parameters.

---
 rtl/multicycle_control_unit_pkg.sv | 39 +++
 rtl/multicycle_control_unit_cu_decode.sv | 54 +++++
 rtl/multicycle_control_unit.sv | 140 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: instruction classes,
// FSM state codes and the datapath select bundle.
package multicycle_control_unit_pkg;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MOV = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_BR  = 2'b11;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [1:0] MUX1_BR    = 2'b00;
  localparam logic [1:0] MUX1_ALU   = 2'b01;
  localparam logic [1:0] MUX1_LOAD  = 2'b10;
  localparam logic [1:0] MUX1_MOV   = 2'b11;
  localparam logic [1:0] MUX5_ALU   = 2'b00;
  localparam logic [1:0] MUX5_MEM   = 2'b01;
  localparam logic [1:0] MUX5_PASS  = 2'b11;
  localparam logic [1:0] MUX6_SEQ   = 2'b00;
  localparam logic [1:0] MUX6_BR    = 2'b01;
  localparam logic [1:0] MUX6_BR_LT = 2'b10;

  typedef struct packed {
    logic [1:0] mux1;
    logic       mux2;
    logic       mux4;
    logic [1:0] mux5;
    logic [1:0] mux6;
    logic       comparator;
    logic [2:0] regs_bank;
  } sel_t;

  localparam sel_t SEL_IDLE = '0;

endpackage

// File: rtl/multicycle_control_unit_cu_decode.sv
// Combinational decode of an instruction word into the datapath select
// bundle and ALU operation; the top registers the result during DECODE.
module cu_decode
  import multicycle_control_unit_pkg::*;
#(
  parameter int INSTR_W  = 24,
  parameter int ALU_OP_W = 6,
  parameter int ALU_LSB  = 4
) (
  input  logic [INSTR_W-1:0]  instr,
  output sel_t                sel,
  output logic [ALU_OP_W-1:0] alu
);

  logic [1:0] cls;
  logic [2:0] sub_op;

  assign cls    = instr[INSTR_W-1 -: 2];
  assign sub_op = instr[14:12];

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    sel = SEL_IDLE;
    alu = '1;
    unique case (cls)
      CLS_ALU: begin
        sel.mux1 = MUX1_ALU;
        sel.mux2 = 1'b1;
        alu      = instr[ALU_LSB +: ALU_OP_W];
      end
      CLS_MOV: begin
        sel.mux1      = MUX1_MOV;
        sel.mux5      = MUX5_PASS;
        sel.regs_bank = {1'b0, instr[13:12]};
      end
      CLS_MEM: begin
        sel.mux1      = instr[0] ? MUX1_ALU : MUX1_LOAD;
        sel.mux2      = 1'b1;
        sel.mux4      = 1'b1;
        sel.mux5      = MUX5_MEM;
        sel.regs_bank = {3{instr[0]}};
      end
      CLS_BR: begin
        sel.mux1       = MUX1_BR;
        sel.mux5       = MUX5_PASS;
        sel.comparator = ~instr[12];
        sel.mux6       = (sub_op == 3'b011 || sub_op == 3'b100) ? MUX6_BR_LT : MUX6_BR;
        sel.regs_bank  = (sub_op == 3'b011) ? 3'b011 : 3'b111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// registered datapath selects, single-cycle strobes and a sticky timeout error.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int INSTR_W  = 24,
  parameter int ALU_OP_W = 6,
  parameter int ALU_LSB  = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                halt,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                ir_we,
  output logic                pc_we,
  output logic                reg_we,
  output logic                flags_we,
  output logic                dmem_we,
  output logic [1:0]          mux1,
  output logic [1:0]          mux5,
  output logic [1:0]          mux6,
  output logic                mux2,
  output logic                mux4,
  output logic                comparator,
  output logic [2:0]          regs_bank,
  output logic [ALU_OP_W-1:0] alu,
  output logic                err,
  output logic                busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]          state;
  logic [INSTR_W-1:0]  ir;
  logic [CNT_W-1:0]    wait_cnt;
  sel_t                sel_q, sel_d;
  logic [ALU_OP_W-1:0] alu_q, alu_d;
  logic [1:0]          cls;
  logic                is_store;
  logic                fetch_go;

  cu_decode #(
    .INSTR_W (INSTR_W),
    .ALU_OP_W(ALU_OP_W),
    .ALU_LSB (ALU_LSB)
  ) u_decode (
    .instr(ir),
    .sel  (sel_d),
    .alu  (alu_d)
  );

  assign cls      = ir[INSTR_W-1 -: 2];
  assign is_store = ir[0];
  assign fetch_go = (state == ST_FETCH) && !halt && !err;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH;
      ir       <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
      sel_q    <= SEL_IDLE;
      alu_q    <= '1;
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (!fetch_go) begin
            wait_cnt <= '0;
          end else if (imem_ready) begin
            ir       <= instr;
            wait_cnt <= '0;
            state    <= ST_DECODE;
          end else if (wait_cnt == CNT_LAST) begin
            err      <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DECODE: begin
          sel_q <= sel_d;
          alu_q <= alu_d;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          wait_cnt <= '0;
          unique case (cls)
            CLS_BR:  state <= ST_FETCH;
            CLS_MEM: state <= ST_MEM;
            default: state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (dmem_ready) begin
            wait_cnt <= '0;
            state    <= is_store ? ST_FETCH : ST_WB;
          end else if (wait_cnt == CNT_LAST) begin
            // Abandon the access; the sticky error then blocks further fetches.
            err      <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_FETCH;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_WB:   state <= ST_FETCH;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // The fetch request is gated by rst so nothing is requested while held in reset.
  assign imem_req = fetch_go && !rst;
  assign ir_we    = imem_req && imem_ready;
  assign dmem_req = (state == ST_MEM);
  assign dmem_we  = dmem_req && is_store;
  assign reg_we   = (state == ST_WB);
  assign flags_we = (state == ST_WB) && (cls == CLS_ALU);
  assign pc_we    = ((state == ST_EXEC) && (cls == CLS_BR))
                 || (dmem_req && dmem_ready && is_store)
                 || (state == ST_WB);
  assign busy     = (state != ST_FETCH);

  assign mux1       = sel_q.mux1;
  assign mux2       = sel_q.mux2;
  assign mux4       = sel_q.mux4;
  assign mux5       = sel_q.mux5;
  assign mux6       = sel_q.mux6;
  assign comparator = sel_q.comparator;
  assign regs_bank  = sel_q.regs_bank;
  assign alu        = alu_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed and random instructions compared cycle by
// cycle against a schedule built from the instruction-level timing rules.
module tb_multicycle_control_unit;

  localparam int TO = 15;
  localparam logic [17:0] RST_SEL = {12'b0, 6'h3F};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] instr = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        halt = 1'b1;
  logic        imem_req, dmem_req, ir_we, pc_we, reg_we, flags_we, dmem_we;
  logic [1:0]  mux1, mux5, mux6;
  logic        mux2, mux4, comparator;
  logic [2:0]  regs_bank;
  logic [5:0]  alu;
  logic        err, busy;

  int          checks = 0;
  int          fails = 0;
  logic        err_exp = 1'b0;
  logic [17:0] prev_sel = RST_SEL;

  multicycle_control_unit #(
    .INSTR_W(24), .ALU_OP_W(6), .ALU_LSB(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .halt(halt), .imem_req(imem_req),
    .dmem_req(dmem_req), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .flags_we(flags_we), .dmem_we(dmem_we), .mux1(mux1), .mux5(mux5),
    .mux6(mux6), .mux2(mux2), .mux4(mux4), .comparator(comparator),
    .regs_bank(regs_bank), .alu(alu), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic coin();
    return 1'($urandom);
  endfunction

  // Expected selects {mux1,mux2,mux4,mux5,mux6,comparator,regs_bank,alu} by instruction class.
  function automatic logic [17:0] exp_sel(input logic [23:0] ins);
    logic [1:0] m1, m5, m6;
    logic       m2, m4, cmp;
    logic [2:0] rb, sub;
    logic [5:0] a;
    m1 = 2'b00; m5 = 2'b00; m6 = 2'b00; m2 = 1'b0; m4 = 1'b0; cmp = 1'b0;
    rb = 3'b000; a = 6'h3F; sub = ins[14:12];
    case (ins[23:22])
      2'b00: begin m1 = 2'b01; m2 = 1'b1; a = ins[9:4]; end
      2'b01: begin m1 = 2'b11; m5 = 2'b11; rb = {1'b0, ins[13:12]}; end
      2'b10: begin
        m1 = ins[0] ? 2'b01 : 2'b10; m2 = 1'b1; m4 = 1'b1; m5 = 2'b01;
        rb = ins[0] ? 3'b111 : 3'b000;
      end
      default: begin
        m5 = 2'b11; cmp = (sub % 2) == 0;
        m6 = (sub == 3 || sub == 4) ? 2'b10 : 2'b01;
        rb = (sub == 3) ? 3'b011 : 3'b111;
      end
    endcase
    return {m1, m2, m4, m5, m6, cmp, rb, a};
  endfunction

  // exp_st = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, flags_we, busy}
  task automatic step(input string tag, input logic [7:0] exp_st, input logic imr,
                      input logic dmr, input logic hlt, input logic [23:0] ins);
    logic [8:0]  obs, want;
    logic [17:0] obs_sel;
    @(negedge clk);
    imem_ready = imr; dmem_ready = dmr; halt = hlt; instr = ins;
    #1;
    obs  = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, flags_we, busy, err};
    want = {exp_st, err_exp};
    checks++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s strobes observed=%b expected=%b", tag, obs, want);
    end
    obs_sel = {mux1, mux2, mux4, mux5, mux6, comparator, regs_bank, alu};
    checks++;
    assert (obs_sel === prev_sel) else begin
      fails++;
      $error("FAIL %s selects observed=%h expected=%h", tag, obs_sel, prev_sel);
    end
  endtask

  task automatic do_reset(input string tag);
    logic [8:0]  obs;
    logic [17:0] obs_sel;
    @(negedge clk);
    rst = 1'b1; halt = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    err_exp  = 1'b0;
    prev_sel = RST_SEL;
    obs = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, flags_we, busy, err};
    checks++;
    assert (obs === 9'b0) else begin
      fails++;
      $error("FAIL %s strobes observed=%b expected=%b", tag, obs, 9'b0);
    end
    obs_sel = {mux1, mux2, mux4, mux5, mux6, comparator, regs_bank, alu};
    checks++;
    assert (obs_sel === RST_SEL) else begin
      fails++;
      $error("FAIL %s selects observed=%h expected=%h", tag, obs_sel, RST_SEL);
    end
    #2 rst = 1'b0;
  endtask

  // di/dm: wait cycles before ready (>= TO means never); cut>0 stops after that many MEM cycles.
  task automatic run_instr(input logic [23:0] ins, input int di, input int dm, input int cut);
    logic [17:0] ns;
    logic        br, mem, st, alu_c, rdy;
    ns    = exp_sel(ins);
    br    = ins[23:22] == 2'b11;
    mem   = ins[23:22] == 2'b10;
    alu_c = ins[23:22] == 2'b00;
    st    = ins[0];
    for (int k = 0; k < TO; k++) begin
      rdy = (k == di);
      step("fetch", {1'b1, rdy, 6'b0}, rdy, coin(), 1'b0, ins);
      if (rdy) break;
    end
    if (di >= TO) begin
      err_exp = 1'b1;
      step("fetch_timeout", 8'b0, 1'b1, 1'b0, 1'b0, ins);
      return;
    end
    step("decode", 8'b0000_0001, coin(), coin(), coin(), 24'($urandom));
    prev_sel = ns;
    step("exec", {5'b0, br, 1'b0, 1'b1}, coin(), coin(), coin(), 24'($urandom));
    if (br) return;
    if (mem) begin
      for (int k = 0; k < TO; k++) begin
        if (cut > 0 && k == cut) return;
        rdy = (k == dm);
        step("mem", {2'b0, 1'b1, st, 1'b0, rdy && st, 1'b0, 1'b1}, coin(), rdy, coin(),
             24'($urandom));
        if (rdy) break;
      end
      if (dm >= TO) begin
        err_exp = 1'b1;
        step("mem_timeout", 8'b0, 1'b1, 1'b1, 1'b0, ins);
        return;
      end
      if (st) return;
    end
    step("wb", {4'b0, 1'b1, 1'b1, alu_c, 1'b1}, coin(), coin(), coin(), 24'($urandom));
  endtask

  initial begin
    int di, dm;
    do_reset("reset_initial");

    for (int k = 0; k < 3; k++) step("halt", 8'b0, 1'b1, coin(), 1'b1, 24'($urandom));

    run_instr(24'h000130, 0, 0, 0);
    run_instr(24'h800000, 0, 3, 0);
    run_instr(24'h800001, 0, 0, 0);
    run_instr(24'h800001, 2, 2, 0);
    run_instr(24'h403000, 1, 0, 0);
    for (int s = 0; s < 5; s++) run_instr(24'hC00000 | (24'(s) << 12), 0, 0, 0);
    run_instr(24'h800000, TO - 1, TO - 1, 0);
    run_instr(24'h800001, TO - 1, TO - 1, 0);

    for (int n = 0; n < 40; n++) begin
      di = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 2));
      dm = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 2));
      run_instr(24'($urandom), di, dm, 0);
    end

    run_instr(24'h800000, 0, TO, 2);
    do_reset("reset_mid_mem");

    run_instr(24'h000130, TO, 0, 0);
    step("err_sticky", 8'b0, 1'b1, 1'b0, 1'b0, 24'h000130);
    do_reset("reset_after_fetch_timeout");

    run_instr(24'h800000, 0, TO, 0);
    step("err_sticky_mem", 8'b0, 1'b1, 1'b1, 1'b0, 24'h000130);
    do_reset("reset_after_mem_timeout");
    run_instr(24'h000250, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
